// File: rtl/match_result_collector.sv
// Collects per-LMT search results into small FIFOs and serialises them through one
// round-robin arbitrated, valid/ready output register. Optional macro: MRC_MISS_FILTER_EN.
module match_result_collector #(
  parameter int NUM_LMTS       = 5,
  parameter int LMT_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int LMT_ID_WIDTH   = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_LMTS-1:0]                lmt_search_en,
  input  logic [NUM_LMTS-1:0]                lmt_match_found,
  input  logic [NUM_LMTS*LMT_ADDR_WIDTH-1:0] lmt_match_addr,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [LMT_ID_WIDTH-1:0]            res_lmt_id,
  output logic                               res_hit,
  output logic [LMT_ADDR_WIDTH-1:0]          res_addr,
  input  logic                               drop_clr,
  output logic [15:0]                        drop_count,
  output logic                               overflow,
  output logic [NUM_LMTS-1:0]                q_empty
);

  localparam int IDX_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = LMT_ADDR_WIDTH + 1;
  localparam int DROP_W  = $clog2(NUM_LMTS + 1);

  logic [ENTRY_W-1:0]      mem_r [NUM_LMTS][FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r [NUM_LMTS];
  logic [PTR_W-1:0]        rd_ptr_r [NUM_LMTS];
  logic [LMT_ID_WIDTH-1:0] rr_ptr_r;

  logic [NUM_LMTS-1:0]     empty_s;
  logic [NUM_LMTS-1:0]     full_s;
  logic [NUM_LMTS-1:0]     push_req_s;
  logic [NUM_LMTS-1:0]     push_s;
  logic [NUM_LMTS-1:0]     pop_s;
  logic [NUM_LMTS-1:0]     drop_s;
  logic                    load_s;
  logic                    grant_valid_s;
  logic [LMT_ID_WIDTH-1:0] grant_idx_s;
  logic [LMT_ID_WIDTH-1:0] next_rr_s;
  logic [LMT_ID_WIDTH:0]   scan_sum_s;
  logic [LMT_ID_WIDTH-1:0] scan_idx_s;
  logic                    scan_sel_s;
  logic [ENTRY_W-1:0]      head_s;
  logic [DROP_W-1:0]       drops_s;
  logic [16:0]             drop_sum_s;

`ifdef MRC_MISS_FILTER_EN
  assign push_req_s = lmt_search_en & lmt_match_found;
`else
  assign push_req_s = lmt_search_en;
`endif

  assign load_s  = !res_valid || res_ready;
  assign q_empty = empty_s;

  // Queue status: the extra pointer bit separates full from empty when indices coincide.
  always_comb begin
    empty_s = '0;
    full_s  = '0;
    for (int i = 0; i < NUM_LMTS; i++) begin
      empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
      full_s[i]  = (wr_ptr_r[i][PTR_W-1] != rd_ptr_r[i][PTR_W-1]) &&
                   (wr_ptr_r[i][IDX_W-1:0] == rd_ptr_r[i][IDX_W-1:0]);
    end
  end

  // Round-robin arbiter: first non-empty queue at or after rr_ptr, wrapping at NUM_LMTS.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    scan_sum_s    = '0;
    scan_idx_s    = '0;
    scan_sel_s    = 1'b0;
    for (int k = 0; k < NUM_LMTS; k++) begin
      scan_sum_s    = {1'b0, rr_ptr_r} + (LMT_ID_WIDTH+1)'(k);
      scan_idx_s    = (scan_sum_s >= (LMT_ID_WIDTH+1)'(NUM_LMTS)) ?
                      LMT_ID_WIDTH'(scan_sum_s - (LMT_ID_WIDTH+1)'(NUM_LMTS)) :
                      LMT_ID_WIDTH'(scan_sum_s);
      scan_sel_s    = load_s && !grant_valid_s && !empty_s[scan_idx_s];
      grant_idx_s   = scan_sel_s ? scan_idx_s : grant_idx_s;
      grant_valid_s = grant_valid_s | scan_sel_s;
    end
    next_rr_s = (grant_idx_s == LMT_ID_WIDTH'(NUM_LMTS - 1)) ? '0 : grant_idx_s + 1'b1;
    head_s    = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s][IDX_W-1:0]];
  end

  // Push/pop/drop decisions; a full queue still accepts when it pops in the same cycle.
  always_comb begin
    pop_s   = '0;
    push_s  = '0;
    drop_s  = '0;
    drops_s = '0;
    for (int i = 0; i < NUM_LMTS; i++) begin
      pop_s[i]  = grant_valid_s && (grant_idx_s == LMT_ID_WIDTH'(i));
      push_s[i] = push_req_s[i] && (!full_s[i] || pop_s[i]);
      drop_s[i] = push_req_s[i] && full_s[i] && !pop_s[i];
      drops_s   = drops_s + DROP_W'(drop_s[i]);
    end
    drop_sum_s = {1'b0, drop_count} + 17'(drops_s);
  end

  // Queue pointers advance by one on push/pop and wrap through the extra bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LMTS; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LMTS; i++) begin
        wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(push_s[i]);
        rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(pop_s[i]);
      end
    end
  end

  // Queue storage: entry is {hit, addr}; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LMTS; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i][IDX_W-1:0]] <=
          {lmt_match_found[i], lmt_match_addr[i*LMT_ADDR_WIDTH +: LMT_ADDR_WIDTH]};
      end
    end
  end

  // Output register and round-robin pointer; payload holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_lmt_id <= '0;
      res_hit    <= 1'b0;
      res_addr   <= '0;
      rr_ptr_r   <= '0;
    end else if (load_s) begin
      res_valid <= grant_valid_s;
      if (grant_valid_s) begin
        res_lmt_id <= grant_idx_s;
        res_hit    <= head_s[LMT_ADDR_WIDTH];
        res_addr   <= head_s[LMT_ADDR_WIDTH] ? head_s[LMT_ADDR_WIDTH-1:0] : '0;
        rr_ptr_r   <= next_rr_s;
      end
    end
  end

  // Drop accounting: a clear pulse restarts the count from this cycle's drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= 16'd0;
      overflow   <= 1'b0;
    end else if (drop_clr) begin
      drop_count <= 16'(drops_s);
      overflow   <= (drops_s != '0);
    end else begin
      drop_count <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
      overflow   <= overflow | (drops_s != '0);
    end
  end

endmodule

// File: tb/tb_match_result_collector.sv
// Self-checking bench for match_result_collector: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_match_result_collector;

  localparam int NL = 5;
  localparam int AW = 8;
  localparam int FD = 4;
  localparam int IW = 3;
  localparam logic [34:0] RESET_VEC = {1'b0, 3'd0, 1'b0, 8'd0, 16'd0, 1'b0, 5'b11111};

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NL-1:0]  lmt_search_en = '0;
  logic [NL-1:0]  lmt_match_found = '0;
  logic [NL*AW-1:0] lmt_match_addr = '0;
  logic           res_ready = 1'b0;
  logic           drop_clr = 1'b0;
  logic           res_valid;
  logic [IW-1:0]  res_lmt_id;
  logic           res_hit;
  logic [AW-1:0]  res_addr;
  logic [15:0]    drop_count;
  logic           overflow;
  logic [NL-1:0]  q_empty;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int          mq [NL][$];
  logic        m_valid;
  logic [IW-1:0] m_id;
  logic        m_hit;
  logic [AW-1:0] m_addr;
  int          m_rr;
  int          m_cnt;
  logic        m_ovf;

  match_result_collector #(
    .NUM_LMTS(NL), .LMT_ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .LMT_ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lmt_search_en(lmt_search_en), .lmt_match_found(lmt_match_found),
    .lmt_match_addr(lmt_match_addr),
    .res_valid(res_valid), .res_ready(res_ready), .res_lmt_id(res_lmt_id),
    .res_hit(res_hit), .res_addr(res_addr),
    .drop_clr(drop_clr), .drop_count(drop_count), .overflow(overflow),
    .q_empty(q_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] raw_vec();
    return {res_valid, res_lmt_id, res_hit, res_addr, drop_count, overflow, q_empty};
  endfunction

  function automatic logic [34:0] dut_vec();
    return {res_valid, res_valid ? res_lmt_id : 3'd0, res_valid ? res_hit : 1'b0,
            res_valid ? res_addr : 8'd0, drop_count, overflow, q_empty};
  endfunction

  function automatic logic [34:0] exp_vec();
    logic [NL-1:0] emp;
    emp = '0;
    for (int i = 0; i < NL; i++) emp[i] = (mq[i].size() == 0);
    return {m_valid, m_valid ? m_id : 3'd0, m_valid ? m_hit : 1'b0,
            m_valid ? m_addr : 8'd0, 16'(m_cnt), m_ovf, emp};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mq[i].delete();
    m_valid = 1'b0; m_id = '0; m_hit = 1'b0; m_addr = '0;
    m_rr = 0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  // Advance the model by one clock using the inputs now applied, then clock the DUT.
  task automatic tick();
    int g; int drops; int e; logic ld; logic req;
    ld = !m_valid || res_ready;
    g = -1;
    if (ld) begin
      for (int k = 0; k < NL; k++) begin
        int idx;
        idx = (m_rr + k) % NL;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_valid = 1'b1;
      m_id = 3'(g);
      m_hit = e[8];
      m_addr = e[8] ? e[7:0] : 8'd0;
      m_rr = (g + 1) % NL;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    drops = 0;
    for (int i = 0; i < NL; i++) begin
      req = lmt_search_en[i];
`ifdef MRC_MISS_FILTER_EN
      req = req && lmt_match_found[i];
`endif
      if (req) begin
        if (mq[i].size() < FD) mq[i].push_back(int'({lmt_match_found[i], lmt_match_addr[i*AW +: AW]}));
        else drops++;
      end
    end
    if (drop_clr) begin
      m_cnt = drops;
      m_ovf = (drops > 0);
    end else begin
      m_cnt = (m_cnt + drops > 65535) ? 65535 : m_cnt + drops;
      m_ovf = m_ovf || (drops > 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lmt_search_en = '0; lmt_match_found = '0; lmt_match_addr = '0;
    drop_clr = 1'b0; res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int lmt, input logic found, input logic [AW-1:0] addr);
    lmt_search_en = '0;
    lmt_search_en[lmt] = 1'b1;
    lmt_match_found[lmt] = found;
    lmt_match_addr[lmt*AW +: AW] = addr;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (raw_vec() !== RESET_VEC) begin
      errors++; $display("FAIL reset_async: got %h want %h", raw_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if (raw_vec() !== RESET_VEC) begin
      errors++; $display("FAIL reset_release: got %h want %h", raw_vec(), RESET_VEC);
    end
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1;
    strobe(0, 1'b1, 8'd40);
    tick();
    lmt_search_en = '0;
    checks++;
    if ({res_valid, q_empty[0]} !== 2'b00) begin
      errors++; $display("FAIL single_latency: got valid=%b q_empty0=%b want 0 0", res_valid, q_empty[0]);
    end
    tick();
    checks++;
    if ({res_valid, res_lmt_id, res_hit, res_addr} !== {1'b1, 3'd0, 1'b1, 8'd40}) begin
      errors++; $display("FAIL single_result: got %b %0d %b %0d want 1 0 1 40",
                         res_valid, res_lmt_id, res_hit, res_addr);
    end
    tick();
    checks++;
    if (dut_vec() !== exp_vec() || res_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_all_five();
    do_reset();
    res_ready = 1'b1;
    lmt_search_en = 5'b11111;
    lmt_match_found = 5'b11111;
    for (int i = 0; i < NL; i++) lmt_match_addr[i*AW +: AW] = 8'(i * 10);
    tick();
    lmt_search_en = '0;
    for (int k = 0; k < NL; k++) begin
      tick();
      checks++;
      if ({res_valid, res_lmt_id, res_hit, res_addr} !== {1'b1, 3'(k), 1'b1, 8'(k * 10)}) begin
        errors++; $display("FAIL all_five_order: got %b %0d %b %0d want 1 %0d 1 %0d",
                           res_valid, res_lmt_id, res_hit, res_addr, k, k * 10);
      end
    end
    tick();
    checks++;
    if ({res_valid, drop_count, q_empty} !== {1'b0, 16'd0, 5'b11111}) begin
      errors++; $display("FAIL all_five_end: got %b %0d %b want 0 0 11111", res_valid, drop_count, q_empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    // Park one LMT0 result in the stalled output register so LMT2's queue takes all six.
    strobe(0, 1'b1, 8'h11);
    tick();
    lmt_search_en = '0;
    tick();
    for (int k = 0; k < 6; k++) begin
      strobe(2, 1'b1, 8'(k));
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL ovf_fill: got %h want %h", dut_vec(), exp_vec());
      end
    end
    lmt_search_en = '0;
    checks++;
    if ({drop_count, overflow, res_valid, res_lmt_id} !== {16'd2, 1'b1, 1'b1, 3'd0}) begin
      errors++; $display("FAIL ovf_count: got cnt=%0d ovf=%b v=%b id=%0d want 2 1 1 0",
                         drop_count, overflow, res_valid, res_lmt_id);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({res_valid, res_lmt_id, res_addr} !== {1'b1, 3'd2, 8'(k)}) begin
        errors++; $display("FAIL ovf_drain: got %b %0d %0d want 1 2 %0d", res_valid, res_lmt_id, res_addr, k);
      end
    end
    tick();
    checks++;
    if ({res_valid, q_empty} !== {1'b0, 5'b11111}) begin
      errors++; $display("FAIL ovf_empty: got %b %b want 0 11111", res_valid, q_empty);
    end
  endtask

  task automatic test_back_to_back();
    int d_id[$]; int d_addr[$];
    int bad_order; int bad_alt; int stream_n; int last [NL];
    logic stalled; logic [11:0] held;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      lmt_search_en = 5'b01010;
      lmt_match_found = 5'b01010;
      lmt_match_addr[1*AW +: AW] = 8'(c);
      lmt_match_addr[3*AW +: AW] = 8'(c);
      res_ready = c[0];
      if (res_valid && res_ready) begin d_id.push_back(int'(res_lmt_id)); d_addr.push_back(int'(res_addr)); end
      stalled = res_valid && !res_ready;
      held = {res_lmt_id, res_hit, res_addr};
      tick();
      if (stalled) begin
        checks++;
        if ({res_valid, res_lmt_id, res_hit, res_addr} !== {1'b1, held}) begin
          errors++; $display("FAIL b2b_stall_stable: got %b %h want 1 %h",
                             res_valid, {res_lmt_id, res_hit, res_addr}, held);
        end
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b_model: got %h want %h", dut_vec(), exp_vec());
      end
    end
    stream_n = d_id.size();
    lmt_search_en = '0;
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (res_valid && res_ready) begin d_id.push_back(int'(res_lmt_id)); d_addr.push_back(int'(res_addr)); end
      tick();
    end
    bad_order = 0; bad_alt = 0;
    for (int i = 0; i < NL; i++) last[i] = -1;
    foreach (d_id[j]) begin
      if (d_addr[j] <= last[d_id[j]]) bad_order++;
      last[d_id[j]] = d_addr[j];
      if (j > 0 && j < stream_n && d_id[j] == d_id[j-1]) bad_alt++;
    end
    checks++;
    if (bad_order !== 0) begin
      errors++; $display("FAIL b2b_order: got %0d out-of-order results want 0", bad_order);
    end
    checks++;
    if (bad_alt !== 0 || stream_n < 4) begin
      errors++; $display("FAIL b2b_alternate: got %0d repeats over %0d results want 0 repeats", bad_alt, stream_n);
    end
    checks++;
    if (int'(drop_count) + d_id.size() !== 48 || res_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_accounting: got %0d delivered+dropped want 48", int'(drop_count) + d_id.size());
    end
  endtask

  task automatic test_drop_clr();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      strobe(0, 1'b1, 8'(k));
      tick();
    end
    checks++;
    if ({drop_count, overflow} !== {16'd2, 1'b1}) begin
      errors++; $display("FAIL clr_pre: got %0d %b want 2 1", drop_count, overflow);
    end
    drop_clr = 1'b1;
    tick();
    checks++;
    if ({drop_count, overflow} !== {16'd1, 1'b1}) begin
      errors++; $display("FAIL clr_with_drop: got %0d %b want 1 1", drop_count, overflow);
    end
    lmt_search_en = '0;
    tick();
    drop_clr = 1'b0;
    checks++;
    if ({drop_count, overflow} !== {16'd0, 1'b0} || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL clr_alone: got %0d %b want 0 0", drop_count, overflow);
    end
  endtask

  task automatic test_miss();
    do_reset();
    res_ready = 1'b1;
    strobe(4, 1'b0, 8'hAB);
    tick();
    lmt_search_en = '0;
    tick();
`ifdef MRC_MISS_FILTER_EN
    checks++;
    if ({res_valid, drop_count, q_empty} !== {1'b0, 16'd0, 5'b11111}) begin
      errors++; $display("FAIL miss_filtered: got %b %0d %b want 0 0 11111", res_valid, drop_count, q_empty);
    end
`else
    checks++;
    if ({res_valid, res_lmt_id, res_hit, res_addr} !== {1'b1, 3'd4, 1'b0, 8'd0}) begin
      errors++; $display("FAIL miss_delivered: got %b %0d %b %h want 1 4 0 00",
                         res_valid, res_lmt_id, res_hit, res_addr);
    end
`endif
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL miss_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    lmt_search_en = 5'b11111;
    lmt_match_found = 5'b11111;
    for (int c = 0; c < 13120; c++) begin
      lmt_match_addr = {$urandom, $urandom};
      tick();
      if (c % 2048 == 0) begin
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL sat_progress: got %h want %h", dut_vec(), exp_vec());
        end
      end
    end
    checks++;
    if ({drop_count, overflow} !== {16'hFFFF, 1'b1} || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL sat_final: got %h %b want ffff 1", drop_count, overflow);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      lmt_search_en = NL'($urandom);
      lmt_match_found = NL'($urandom);
      lmt_match_addr = {$urandom, $urandom};
      res_ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      drop_clr = ($urandom_range(0, 63) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic test_midreset();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      lmt_search_en = 5'b11111;
      lmt_match_found = 5'b11111;
      lmt_match_addr = {$urandom, $urandom};
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (raw_vec() !== RESET_VEC) begin
      errors++; $display("FAIL midreset_async: got %h want %h", raw_vec(), RESET_VEC);
    end
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    strobe(1, 1'b1, 8'd77);
    tick();
    lmt_search_en = '0;
    tick();
    checks++;
    if ({res_valid, res_lmt_id, res_addr} !== {1'b1, 3'd1, 8'd77} || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL midreset_flush: got %b %0d %0d want 1 1 77", res_valid, res_lmt_id, res_addr);
    end
    tick();
    checks++;
    if ({res_valid, q_empty} !== {1'b0, 5'b11111}) begin
      errors++; $display("FAIL midreset_empty: got %b %b want 0 11111", res_valid, q_empty);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_all_five();
    test_overflow();
    test_back_to_back();
    test_drop_clr();
    test_miss();
    test_random();
    test_midreset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
